// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register busy scoreboard (x0 hardwired to zero).
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy-clear to the read ports.
module regfile_mp #(
  parameter  int XLEN = 64,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [AW-1:0]   wa [NWR];

  for (genvar j = 0; j < NWR; j++) begin : g_wa
    assign wa[j] = wr_addr[j*AW +: AW];
  end

  // Priority: retiring writes clear, a new claim sets, flush clears everything.
  // NOTE: every variable in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_next[wa[j]] = 1'b0;
    end
    if (sb_set) busy_next[sb_addr] = 1'b1;
    if (flush)  busy_next = '0;
    busy_next[0] = 1'b0;
  end

  // NOTE: state uses non-blocking assignments; with several ports on one address the
  // last (highest-index) scheduled update is the one that lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register array is reset explicitly, so it maps to flops rather than a RAM macro.
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wa[j] != '0)) regs[wa[j]] <= wr_data[j*XLEN +: XLEN];
      end
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            b;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      d = (ra == '0) ? '0 : regs[ra];
      b = busy[ra];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan so the highest-index matching writer is the one forwarded.
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wa[j] == ra) && (ra != '0)) begin
          d = wr_data[j*XLEN +: XLEN];
          b = 1'b0;
        end
      end
`endif
    end

    assign rd_data[i*XLEN +: XLEN] = d;
    assign rd_busy[i]              = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  int tests = 0;
  int fails = 0;

  logic [XLEN-1:0] m_reg [NREG];
  logic [NREG-1:0] m_busy;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
    .sb_addr(sb_addr), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set = 1'b0; sb_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  // What a read of address a should return given current model state and the inputs now applied.
  function automatic void exp_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
    d = (a == 0) ? '0 : m_reg[a];
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0)
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
          d = wr_data[j*XLEN +: XLEN];
          b = 1'b0;
        end
`endif
  endfunction

  // Compare all outputs against the model, mid-cycle (at the falling edge).
  task automatic sample();
    logic [XLEN-1:0] d;
    logic            b;
    @(negedge clk);
    for (int i = 0; i < NRD; i++) begin
      exp_read(rd_addr[i*AW +: AW], d, b);
      check($sformatf("rd_data[%0d]@%0d", i, rd_addr[i*AW +: AW]), rd_data[i*XLEN +: XLEN], d);
      check($sformatf("rd_busy[%0d]@%0d", i, rd_addr[i*AW +: AW]), 64'(rd_busy[i]), 64'(b));
    end
    check("busy_vec", 64'(busy_vec), 64'(m_busy));
  endtask

  // Clock edge: update the model from the rules, then release the inputs 1 time unit later.
  task automatic advance();
    logic [NREG-1:0] nb;
    logic            written;
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREG; r++) m_reg[r] = '0;
      m_busy = '0;
    end else begin
      nb = '0;
      for (int a = 1; a < NREG; a++) begin
        written = 1'b0;
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(a)) written = 1'b1;
        if (flush)                            nb[a] = 1'b0;
        else if (sb_set && sb_addr == AW'(a)) nb[a] = 1'b1;
        else if (written)                     nb[a] = 1'b0;
        else                                  nb[a] = m_busy[a];
      end
      m_busy = nb;
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0)
          m_reg[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    end
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  initial begin
    idle();
    set_rd(5'd5, 5'd31);
    reset = 1'b1;
    advance();
    idle();

    // Post-reset reads are all zero and idle.
    sample();
    check("rst rd_data0", rd_data[63:0], 64'h0);
    check("rst rd_data1", rd_data[127:64], 64'h0);
    check("rst rd_busy", 64'(rd_busy), 64'h0);
    check("rst busy_vec", 64'(busy_vec), 64'h0);
    advance();

    // Same-cycle write/read of reg 12.
    set_rd(5'd12, 5'd12);
    set_wr(0, 5'd12, 64'hAB);
    sample();
`ifdef REGFILE_BYPASS_EN
    check("bypass rd_data", rd_data[63:0], 64'hAB);
`else
    check("nobypass rd_data", rd_data[63:0], 64'h0);
`endif
    check("bypass rd_busy", 64'(rd_busy[0]), 64'h0);
    advance();
    idle();

    // Simple write then read; write to reg 0 discarded.
    set_wr(0, 5'd7, 64'hDEAD_BEEF);
    set_rd(5'd7, 5'd0);
    tick();
    idle();
    sample();
    check("reg7", rd_data[63:0], 64'hDEAD_BEEF);
    advance();
    set_wr(1, 5'd0, 64'h1234);
    tick();
    idle();
    sample();
    check("reg0", rd_data[127:64], 64'h0);
    advance();

    // Collision: port 1 wins.
    set_wr(0, 5'd3, 64'h11);
    set_wr(1, 5'd3, 64'h22);
    set_rd(5'd3, 5'd3);
    tick();
    idle();
    sample();
    check("collision", rd_data[63:0], 64'h22);
    advance();

    // Scoreboard sequence on reg 9 then flush over a set on reg 4.
    set_rd(5'd9, 5'd4);
    sb_set = 1'b1; sb_addr = 5'd9;
    tick();
    idle();
    sample();
    check("sb set 9", 64'(busy_vec[9]), 64'h1);
    advance();
    set_wr(0, 5'd9, 64'h99);
    sb_set = 1'b1; sb_addr = 5'd9;
    tick();
    idle();
    sample();
    check("set wins 9", 64'(busy_vec[9]), 64'h1);
    advance();
    set_wr(1, 5'd9, 64'h9A);
    tick();
    idle();
    sample();
    check("clear 9", 64'(busy_vec[9]), 64'h0);
    advance();
    sb_set = 1'b1; sb_addr = 5'd4;
    flush = 1'b1;
    tick();
    idle();
    sample();
    check("flush", 64'(busy_vec), 64'h0);
    advance();

    // Reset beats a concurrent write.
    for (int r = 1; r <= 4; r += 2) begin
      set_wr(0, AW'(r), 64'(r) * 64'h101);
      set_wr(1, AW'(r + 1), 64'(r + 1) * 64'h101);
      tick();
      idle();
    end
    set_rd(5'd1, 5'd4);
    sample();
    check("pre-reset reg4", rd_data[127:64], 64'h404);
    advance();
    reset = 1'b1;
    set_wr(0, 5'd5, 64'h555);
    sb_set = 1'b1; sb_addr = 5'd6;
    advance();
    idle();
    for (int r = 1; r <= 5; r += 2) begin
      set_rd(AW'(r), AW'(r + 1));
      sample();
      check($sformatf("post-reset reg%0d", r), rd_data[63:0], 64'h0);
      check($sformatf("post-reset reg%0d", r + 1), rd_data[127:64], 64'h0);
      check("post-reset busy_vec", 64'(busy_vec), 64'h0);
      advance();
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 1) == 1)
          set_wr(j, AW'($urandom_range(0, 7)), {32'($urandom), 32'($urandom)});
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = AW'($urandom_range(0, 7));
      flush   = ($urandom_range(0, 19) == 0);
      reset   = ($urandom_range(0, 49) == 0);
      set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
